// File: rtl/mux_41_arbiter.sv
// Round-robin arbiter and select sequencer for the shared 4:1 single-bit mux.
// Four requesters (req[0]..req[3] -> mux inputs a..d) share the mux. Each grant
// is registered and one-hot, and lasts at most MAX_HOLD consecutive cycles. The
// mux selects {sel1,sel0} follow the granted index. They hold their last value
// while idle so the mux does not toggle.
module mux_41_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       sel1,
  output logic       sel0,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Last hold-counter value before a grant is forced to release.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;

  logic             win_valid;
  logic [1:0]       win_idx;
  logic             arbitrate;

  // Priority search starting at ptr.
  // Walk the offsets from farthest to nearest so the closest requester wins.
  // When only the current owner still requests, it is found last and re-granted.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) begin
        win_valid = 1'b1;
        win_idx   = ptr_q + 2'(i);
      end
    end
  end

  // Next-state logic.
  // The owner keeps the mux while it requests and has hold budget left.
  // Otherwise arbitration runs at the same edge, so there is no idle bubble.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    arbitrate = 1'b0;

    case (state_q)
      IDLE: begin
        arbitrate = 1'b1;
      end
      GRANT: begin
        if (req[sel_q] && (cnt_q < HOLD_LAST)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          arbitrate = 1'b1;
        end
      end
      default: begin
        arbitrate = 1'b1;
      end
    endcase

    if (arbitrate) begin
      cnt_d = '0;
      if (win_valid) begin
        state_d = GRANT;
        grant_d = 4'b0001 << win_idx;
        sel_d   = win_idx;
        busy_d  = 1'b1;
        ptr_d   = win_idx + 2'd1;
      end else begin
        state_d = IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    end
  end

  // State, pointer, counter and registered outputs; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign sel1  = sel_q[1];
  assign sel0  = sel_q[0];
  assign busy  = busy_q;

endmodule

// File: doc/mux_41_arbiter.md
Name: mux_41_arbiter

Overview:
- Round-robin arbiter and select sequencer for the shared 4:1 single-bit datapath mux (inputs a/b/c/d, selects sel1/sel0).
- Shares the mux between four requesters and drives sel1/sel0 so the granted source's data appears at the mux result.
- Grants are registered and one-hot, and each requester may hold the mux for a bounded number of cycles.
- Sits between the CPU control logic (requesters) and the mux instance.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one grant may last; legal range 1..15.
- CNT_W, 4, width of the internal hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- req  input  4  request vector; req[0] maps to mux input a, req[1] to b, req[2] to c, req[3] to d.
- grant  output  4  registered one-hot grant; all zero when idle.
- sel1  output  1  mux select MSB (index of granted requester, bit 1).
- sel0  output  1  mux select LSB (index of granted requester, bit 0).
- busy  output  1  registered; high when any grant bit is set.

Behaviour:
- Reset (rst_n low, immediate, asynchronous):
  - grant=0000, sel1=0, sel0=0, busy=0.
  - State IDLE, round-robin pointer ptr=0, hold counter cnt=0.
- Pointer and priority:
  - ptr is 2 bits.
  - Priority order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - After every grant issue, ptr = issued index + 1 mod 4.
- IDLE state:
  - If req != 0 at a rising edge: grant the highest-priority set bit at that edge, set {sel1,sel0} to its index, busy=1, cnt=0, and go to GRANT.
  - Latency is one cycle: req high before edge N gives grant visible after edge N.
  - If req == 0: stay IDLE, grant=0000, busy=0, and sel1/sel0 hold their last value (no toggling while idle).
- GRANT state (owner = current grant index):
  - Continue when req[owner]=1 and cnt < MAX_HOLD-1: cnt increments, and grant and sel are unchanged.
  - Release when req[owner]=0, or when cnt == MAX_HOLD-1 (timeout after MAX_HOLD granted cycles).
  - On release, arbitration among the current req, masked by priority from the updated ptr (owner+1), happens at the same edge. There is no idle bubble.
  - Release with other requesters pending: the next winner is granted, sel updates, cnt=0.
  - Release on timeout with only the owner still requesting: the owner is re-granted, grant and sel are unchanged, cnt=0.
  - Release with no requests pending: go to IDLE, grant=0000, busy=0, sel held.
- MAX_HOLD=1: arbitration occurs every cycle, giving pure per-cycle round-robin.
- Requests are level-sensitive and not latched. A req pulse that drops before being sampled at an arbitration edge is lost.
- Invariants:
  - grant is always one-hot or zero.
  - busy == |grant.
  - {sel1,sel0} equals the index of the set grant bit whenever busy=1.
- Reset mid-grant clears everything immediately. After release of reset, arbitration restarts from ptr=0.
- Simultaneous release and new request at the same edge are handled as above. The new grant is never delayed beyond that edge.

Test Plan:
- Reset with rst_n=0 asynchronously mid-cycle while a grant is active -> grant=0000, sel=00, busy=0 immediately; first req=1010 after release grants 0010 (index 1, ptr=0 searches 0,1,...), sel=01.
- From reset, req=1111 held, MAX_HOLD=4 -> grant 0001 for 4 cycles, then 0010, 0100, 1000, 0001, each for 4 cycles, with sel = 00, 01, 10, 11, 00 correspondingly and no idle cycles.
- req=0100 held alone for 10 cycles -> grant=0100 and sel=10 continuously; cnt reloads at each timeout; busy stays 1; no glitch on grant.
- Owner early release: grant=0001 with req changing to 1000 at cycle 2 of the hold -> the next edge grants 1000, sel=11.
- All requests drop while granted -> the next edge gives grant=0000, busy=0, sel holds the previous index; req=0011 afterwards is granted by ptr order (ptr = last owner+1).
- MAX_HOLD=1 build with req=0101 held -> grant alternates 0001, 0100, 0001, ... every cycle, and sel alternates 00, 10.
